// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// serial_pkg -- shared state encodings, default sizes and sample-point helper
// Revision: 1.0
// ============================================================================
package serial_pkg;

  localparam int OVERSAMPLE_DEF  = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DATA_WIDTH_DEF  = 8;

  // k = 0, 1, 2 gives the three vote points centred on the middle of a bit
  function automatic int sample_point(input int oversample, input int k);
    return oversample / 2 - 1 + k;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_M0_DATA = 3'd1,
    ST_START   = 3'd2,
    ST_DATA    = 3'd3,
    ST_BIT9    = 3'd4,
    ST_STOP    = 3'd5
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_rx_bit_sampler.sv
`default_nettype none
// ============================================================================
// serial_rx_bit_sampler -- RX synchroniser, start-edge detect, 2-of-3 bit vote
// Revision: 1.0
// ============================================================================
module serial_rx_bit_sampler
  import serial_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  input  logic tick,
  input  logic cnt_clr,
  output logic rx_s,
  output logic fall_o,
  output logic bit_valid_o,
  output logic bit_o
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] PT_A    = CW'(sample_point(OVERSAMPLE, 0));
  localparam logic [CW-1:0] PT_B    = CW'(sample_point(OVERSAMPLE, 1));
  localparam logic [CW-1:0] PT_C    = CW'(sample_point(OVERSAMPLE, 2));
  localparam logic [CW-1:0] CNT_MAX = CW'(OVERSAMPLE - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_prev;
  logic [CW-1:0]          tick_cnt;
  logic                   samp_a;
  logic                   samp_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= '1;
      rx_prev  <= 1'b1;
      tick_cnt <= '0;
      samp_a   <= 1'b1;
      samp_b   <= 1'b1;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], rx};
      rx_prev <= rx_s;
      if (cnt_clr) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= (tick_cnt == CNT_MAX) ? '0 : tick_cnt + 1'b1;
        if (tick_cnt == PT_A) samp_a <= rx_s;
        if (tick_cnt == PT_B) samp_b <= rx_s;
      end
    end
  end

  assign rx_s        = sync[SYNC_STAGES-1];
  assign fall_o      = rx_prev & ~rx_s;
  // The third vote is the live synchronised value on the deciding tick
  assign bit_valid_o = tick & ~cnt_clr & (tick_cnt == PT_C);
  assign bit_o       = maj3(samp_a, samp_b, rx_s);

endmodule
`default_nettype wire

// File: rtl/serial_rx_input_shifter_reg.sv
`default_nettype none
// ============================================================================
// serial_rx_input_shifter_reg -- serial RX deserialiser (mode 0 / mode 2) into SBUF/RB8
// Revision: 1.0
// ============================================================================
module serial_rx_input_shifter_reg
  import serial_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
  input  logic                  serial_clock_i,
  input  logic                  serial_reset_i_b,
  input  logic                  serial_rx_i,
  input  logic                  serial_sample_tick_i,
  input  logic                  serial_shift_i,
  input  logic                  serial_scon7_sm0_i,
  input  logic                  serial_scon5_sm2_i,
  input  logic                  serial_scon4_ren_i,
  input  logic                  serial_scon0_ri_i,
  output logic [DATA_WIDTH-1:0] serial_data_sbuf_o,
  output logic                  serial_rb8_o,
  output logic                  serial_ri_set_o,
  output logic                  serial_rx_busy_o,
  output logic                  serial_frame_err_o
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  rx_state_t             state;
  rx_state_t             state_nxt;
  logic                  rx_s;
  logic                  fall;
  logic                  bit_valid;
  logic                  rx_bit;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic [DATA_WIDTH-1:0] load_val;
  logic                  bit9;
  logic                  abort;
  logic                  shift_bit;
  logic                  shift_en;
  logic                  bit_clr;
  logic                  load;
  logic                  ferr;
  logic                  bit9_ld;

  serial_rx_bit_sampler #(
    .OVERSAMPLE  (OVERSAMPLE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk         (serial_clock_i),
    .rst_n       (serial_reset_i_b),
    .rx          (serial_rx_i),
    .tick        (serial_sample_tick_i),
    .cnt_clr     (state == ST_IDLE),
    .rx_s        (rx_s),
    .fall_o      (fall),
    .bit_valid_o (bit_valid),
    .bit_o       (rx_bit)
  );

  always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
    if (!serial_reset_i_b) state <= ST_IDLE;
    else                   state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_bit = rx_bit;
    shift_en  = 1'b0;
    bit_clr   = 1'b0;
    load      = 1'b0;
    ferr      = 1'b0;
    bit9_ld   = 1'b0;
    // Leaving receive enable or switching mode mid-frame wins over any pulse
    abort     = (state != ST_IDLE) &&
                (!serial_scon4_ren_i || (serial_scon7_sm0_i != (state != ST_M0_DATA)));
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          bit_clr = 1'b1;
          if (serial_scon4_ren_i && !serial_scon7_sm0_i && !serial_scon0_ri_i)
            state_nxt = ST_M0_DATA;
          else if (serial_scon4_ren_i && serial_scon7_sm0_i && fall)
            state_nxt = ST_START;
        end
        ST_M0_DATA: begin
          shift_bit = rx_s;
          if (serial_shift_i) begin
            shift_en = 1'b1;
            if (bit_cnt == LAST_BIT) begin
              load      = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
        end
        ST_START: if (bit_valid) state_nxt = rx_bit ? ST_IDLE : ST_DATA;
        ST_DATA: begin
          if (bit_valid) begin
            shift_en = 1'b1;
            if (bit_cnt == LAST_BIT) state_nxt = ST_BIT9;
          end
        end
        ST_BIT9: begin
          if (bit_valid) begin
            bit9_ld   = 1'b1;
            state_nxt = ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_valid) begin
            load      = !serial_scon0_ri_i && (!serial_scon5_sm2_i || bit9);
            ferr      = !rx_bit;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign shreg_nxt = {shift_bit, shreg[DATA_WIDTH-1:1]};
  // Mode 0 loads the byte on the same edge as its last shift
  assign load_val  = (state == ST_M0_DATA) ? shreg_nxt : shreg;

  always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
    if (!serial_reset_i_b) begin
      bit_cnt            <= '0;
      shreg              <= '0;
      bit9               <= 1'b0;
      serial_data_sbuf_o <= '0;
      serial_rb8_o       <= 1'b0;
      serial_ri_set_o    <= 1'b0;
      serial_frame_err_o <= 1'b0;
    end else begin
      serial_ri_set_o    <= load;
      serial_frame_err_o <= ferr;
      if (bit_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) shreg <= shreg_nxt;
      if (bit9_ld)  bit9  <= rx_bit;
      if (load) begin
        serial_data_sbuf_o <= load_val;
        if (state == ST_STOP) serial_rb8_o <= bit9;
      end
    end
  end

  assign serial_rx_busy_o = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_rx_input_shifter_reg.sv
`default_nettype none
// ============================================================================
// tb_serial_rx_input_shifter_reg -- directed and random frames against a frame-level model
// Revision: 1.0
// ============================================================================
module tb_serial_rx_input_shifter_reg;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx    = 1'b1;
  logic       tick  = 1'b0;
  logic       shift = 1'b0;
  logic       sm0   = 1'b0;
  logic       sm2   = 1'b0;
  logic       ren   = 1'b0;
  logic       ri    = 1'b0;
  logic [7:0] sbuf;
  logic       rb8;
  logic       ri_set;
  logic       busy;
  logic       ferr;

  int         checks    = 0;
  int         errors    = 0;
  int         ri_pulses = 0;
  int         fe_pulses = 0;
  logic [7:0] exp_sbuf  = 8'h00;
  logic       exp_rb8   = 1'b0;

  always #5 clk = ~clk;

  serial_rx_input_shifter_reg dut (
    .serial_clock_i       (clk),
    .serial_reset_i_b     (rst_n),
    .serial_rx_i          (rx),
    .serial_sample_tick_i (tick),
    .serial_shift_i       (shift),
    .serial_scon7_sm0_i   (sm0),
    .serial_scon5_sm2_i   (sm2),
    .serial_scon4_ren_i   (ren),
    .serial_scon0_ri_i    (ri),
    .serial_data_sbuf_o   (sbuf),
    .serial_rb8_o         (rb8),
    .serial_ri_set_o      (ri_set),
    .serial_rx_busy_o     (busy),
    .serial_frame_err_o   (ferr)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (ri_set) ri_pulses++;
      if (ferr)   fe_pulses++;
    end
  end

  // Frame-level model of a mode-2 reception: returns expected pulse counts
  function automatic void model_m2(input logic [7:0] d, input logic b9, input logic stop,
                                   input logic sm2_v, input logic ri_v,
                                   output int n_ri, output int n_fe);
    n_ri = 0;
    if (!ri_v && (!sm2_v || b9)) begin
      exp_sbuf = d;
      exp_rb8  = b9;
      n_ri     = 1;
    end
    n_fe = stop ? 0 : 1;
  endfunction

  // One oversample period: RX held for 4 clocks, tick on the last one
  task automatic span(input logic level);
    rx = level;
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic idle_spans(input int n);
    for (int i = 0; i < n; i++) span(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic b9, input logic stop,
                            input int n_bits, input int g_bit, input int g_tick);
    logic [10:0] bits;
    bits = {stop, b9, d, 1'b0};
    for (int i = 0; i < n_bits; i++)
      for (int j = 0; j < 16; j++)
        span((i == g_bit && j == g_tick) ? ~bits[i] : bits[i]);
  endtask

  task automatic send_m0(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (3) @(negedge clk);
      shift = 1'b1;
      @(negedge clk);
      shift = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sbuf !== 8'h00) begin errors++; $display("FAIL reset_sbuf got %h want 00", sbuf); end
    checks++; if (rb8 !== 1'b0)    begin errors++; $display("FAIL reset_rb8 got %b want 0", rb8); end
    checks++; if (ri_set !== 1'b0) begin errors++; $display("FAIL reset_ri_set got %b want 0", ri_set); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (ferr !== 1'b0)   begin errors++; $display("FAIL reset_ferr got %b want 0", ferr); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Full mode-2 frame checked against the model
  task automatic check_m2(input string name, input logic [7:0] d, input logic b9, input logic stop,
                          input logic sm2_v, input logic ri_v, input int g_bit, input int g_tick);
    int r0, f0, n_ri, n_fe;
    sm0 = 1'b1; sm2 = sm2_v; ri = ri_v; ren = 1'b1;
    r0 = ri_pulses; f0 = fe_pulses;
    model_m2(d, b9, stop, sm2_v, ri_v, n_ri, n_fe);
    send_frame(d, b9, stop, 11, g_bit, g_tick);
    idle_spans(2);
    checks++; if (ri_pulses - r0 !== n_ri) begin errors++; $display("FAIL %s ri_pulses got %0d want %0d", name, ri_pulses - r0, n_ri); end
    checks++; if (fe_pulses - f0 !== n_fe) begin errors++; $display("FAIL %s fe_pulses got %0d want %0d", name, fe_pulses - f0, n_fe); end
    checks++; if (sbuf !== exp_sbuf) begin errors++; $display("FAIL %s sbuf got %h want %h", name, sbuf, exp_sbuf); end
    checks++; if (rb8 !== exp_rb8)   begin errors++; $display("FAIL %s rb8 got %b want %b", name, rb8, exp_rb8); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL %s busy got %b want 0", name, busy); end
  endtask

  task automatic test_mode2_basic;
    check_m2("m2_basic", 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, -1, 0);
  endtask

  task automatic test_mode2_sm2;
    check_m2("m2_sm2_reject", 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0);
    check_m2("m2_sm2_accept", 8'h44, 1'b1, 1'b1, 1'b1, 1'b0, -1, 0);
  endtask

  task automatic test_false_start;
    int r0, f0;
    sm0 = 1'b1; sm2 = 1'b0; ri = 1'b0; ren = 1'b1;
    r0 = ri_pulses; f0 = fe_pulses;
    for (int i = 0; i < 3; i++) span(1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL false_start_busy_mid got %b want 1", busy); end
    idle_spans(15);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_start_busy_end got %b want 0", busy); end
    checks++; if (ri_pulses - r0 !== 0 || fe_pulses - f0 !== 0) begin
      errors++; $display("FAIL false_start_pulses got ri=%0d fe=%0d want 0", ri_pulses - r0, fe_pulses - f0);
    end
    checks++; if (sbuf !== exp_sbuf) begin errors++; $display("FAIL false_start_sbuf got %h want %h", sbuf, exp_sbuf); end
  endtask

  task automatic test_glitch;
    check_m2("m2_glitch", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 4, 8);
  endtask

  task automatic test_mode0;
    int r0;
    ren = 1'b0; sm0 = 1'b0; ri = 1'b0;
    repeat (2) @(negedge clk);
    ren = 1'b1;
    repeat (2) @(negedge clk);
    r0 = ri_pulses;
    send_m0(8'h4D);
    exp_sbuf = 8'h4D;
    checks++; if (ri_pulses - r0 !== 1) begin errors++; $display("FAIL m0_ri_pulses got %0d want 1", ri_pulses - r0); end
    checks++; if (sbuf !== exp_sbuf) begin errors++; $display("FAIL m0_sbuf got %h want %h", sbuf, exp_sbuf); end
    checks++; if (rb8 !== exp_rb8)   begin errors++; $display("FAIL m0_rb8 got %b want %b", rb8, exp_rb8); end
    ren = 1'b0;
    repeat (2) @(negedge clk);
    sm0 = 1'b1; rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_abort;
    int r0, f0;
    sm0 = 1'b1; sm2 = 1'b0; ri = 1'b0; ren = 1'b1;
    r0 = ri_pulses; f0 = fe_pulses;
    send_frame(8'h0F, 1'b1, 1'b1, 5, -1, 0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", busy); end
    ren = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after got %b want 0", busy); end
    rx = 1'b1;
    idle_spans(20);
    checks++; if (ri_pulses - r0 !== 0 || fe_pulses - f0 !== 0) begin
      errors++; $display("FAIL abort_pulses got ri=%0d fe=%0d want 0", ri_pulses - r0, fe_pulses - f0);
    end
    checks++; if (sbuf !== exp_sbuf) begin errors++; $display("FAIL abort_sbuf got %h want %h", sbuf, exp_sbuf); end
    ren = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_err;
    check_m2("m2_frame_err", 8'h96, 1'b1, 1'b0, 1'b0, 1'b0, -1, 0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        int r0;
        ren = 1'b0; sm0 = 1'b0; ri = 1'b0;
        repeat (2) @(negedge clk);
        ren = 1'b1;
        repeat (2) @(negedge clk);
        r0 = ri_pulses;
        send_m0(d);
        exp_sbuf = d;
        checks++; if (ri_pulses - r0 !== 1) begin errors++; $display("FAIL rand_m0[%0d] ri_pulses got %0d want 1", n, ri_pulses - r0); end
        checks++; if (sbuf !== exp_sbuf) begin errors++; $display("FAIL rand_m0[%0d] sbuf got %h want %h", n, sbuf, exp_sbuf); end
        checks++; if (rb8 !== exp_rb8)   begin errors++; $display("FAIL rand_m0[%0d] rb8 got %b want %b", n, rb8, exp_rb8); end
        ren = 1'b0;
        repeat (2) @(negedge clk);
        sm0 = 1'b1; rx = 1'b1;
        repeat (4) @(negedge clk);
        ren = 1'b1;
      end else begin
        check_m2("rand_m2", d, 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
                 ($urandom_range(0, 3) == 0), -1, 0);
      end
    end
  endtask

  task automatic test_reset_midframe;
    sm0 = 1'b1; sm2 = 1'b0; ri = 1'b0; ren = 1'b1;
    send_frame(8'hFF, 1'b1, 1'b1, 3, -1, 0);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if (sbuf !== 8'h00)  begin errors++; $display("FAIL midreset_sbuf got %h want 00", sbuf); end
    checks++; if (rb8 !== 1'b0)    begin errors++; $display("FAIL midreset_rb8 got %b want 0", rb8); end
    exp_sbuf = 8'h00; exp_rb8 = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_m2("after_reset", 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, -1, 0);
  endtask

  initial begin
    test_reset();
    test_mode2_basic();
    test_mode2_sm2();
    test_false_start();
    test_glitch();
    test_mode0();
    test_abort();
    test_frame_err();
    test_random();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
